// File: rtl/lutram_scan_reader.sv
// rtl/lutram_scan_reader.sv - streams a contiguous LUTRAM address range out on valid/ready
// Optional clear-on-read write-back is enabled by defining LUTRAM_SCAN_CLEAR_EN.
module lutram_scan_reader #(
    parameter int addr_width = 5,
    parameter int data_width = 32,
    parameter int lo         = 0,
    parameter int hi         = 31
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [addr_width-1:0] START_ADDR,
    input  logic [addr_width-1:0] END_ADDR,
    input  logic                  ABORT,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [addr_width-1:0] RAM_ADDR,
    input  logic [data_width-1:0] RAM_D,
    output logic                  RAM_WE,
    output logic [addr_width-1:0] RAM_WADDR,
    output logic [data_width-1:0] RAM_WDATA,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [data_width-1:0] OUT_DATA,
    output logic [addr_width-1:0] OUT_ADDR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
    localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

    state_t                state_q, state_d;
    logic [addr_width-1:0] ram_addr_q, ram_addr_d;
    logic [addr_width-1:0] end_q, end_d;
    logic [addr_width-1:0] out_addr_q, out_addr_d;
    logic [data_width-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;
    logic [addr_width-1:0] next_addr;
    logic                  take;

    // Address after the current one, wrapping from the top of the store back to the bottom.
    assign next_addr = (ram_addr_q == HI_A) ? LO_A : ram_addr_q + 1'b1;

    // A capture happens whenever the holding register is free or is being drained this cycle.
    assign take = (state_q == SCAN) && !ABORT && (!out_valid_q || OUT_READY);

    // Next-state and holding-register update; ABORT wins over any capture or completion.
    always_comb begin
        state_d     = state_q;
        ram_addr_d  = ram_addr_q;
        end_d       = end_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (START && !ABORT) begin
                    end_d      = END_ADDR;
                    ram_addr_d = START_ADDR;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (ABORT) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (take) begin
                    out_data_d  = RAM_D;
                    out_addr_d  = ram_addr_q;
                    out_valid_d = 1'b1;
                    if (ram_addr_q == end_q) begin
                        state_d = DRAIN;
                    end else begin
                        ram_addr_d = next_addr;
                    end
                end
            end
            DRAIN: begin
                if (ABORT) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end else if (out_valid_q && OUT_READY) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            ram_addr_q  <= LO_A;
            end_q       <= LO_A;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            end_q       <= end_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign BUSY      = (state_q != IDLE);
    assign DONE      = done_q;
    assign RAM_ADDR  = ram_addr_q;
    assign OUT_VALID = out_valid_q;
    assign OUT_DATA  = out_data_q;
    assign OUT_ADDR  = out_addr_q;
    assign RAM_WDATA = '0;

`ifdef LUTRAM_SCAN_CLEAR_EN
    // The write lands on the capture edge; the store's read data is sampled before it changes.
    assign RAM_WE    = take;
    assign RAM_WADDR = ram_addr_q;
`else
    assign RAM_WE    = 1'b0;
    assign RAM_WADDR = LO_A;
`endif

endmodule

// File: tb/tb_lutram_scan_reader.sv
// tb/tb_lutram_scan_reader.sv - randomized self-checking bench for lutram_scan_reader
module tb_lutram_scan_reader;

    logic        CLK;
    logic        RST_N;
    logic        START;
    logic [4:0]  START_ADDR;
    logic [4:0]  END_ADDR;
    logic        ABORT;
    logic        BUSY;
    logic        DONE;
    logic [4:0]  RAM_ADDR;
    logic [31:0] RAM_D;
    logic        RAM_WE;
    logic [4:0]  RAM_WADDR;
    logic [31:0] RAM_WDATA;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_DATA;
    logic [4:0]  OUT_ADDR;

    int checks = 0;
    int errors = 0;

    // Store model: base contents plus a per-entry "cleared in this epoch" mark.
    logic [31:0] base [32];
    logic [31:0] ref_mem [32];
    int          clr_epoch [32];
    int          epoch;

    lutram_scan_reader #(
        .addr_width(5), .data_width(32), .lo(0), .hi(31)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .START_ADDR(START_ADDR),
        .END_ADDR(END_ADDR), .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE),
        .RAM_ADDR(RAM_ADDR), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_WADDR(RAM_WADDR),
        .RAM_WDATA(RAM_WDATA), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_DATA(OUT_DATA), .OUT_ADDR(OUT_ADDR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign RAM_D = (clr_epoch[RAM_ADDR] == epoch) ? 32'd0 : base[RAM_ADDR];

    // Store write port: a write zeroes the entry until the next reload.
    always @(posedge CLK) begin
        if (RAM_WE) clr_epoch[RAM_WADDR] <= epoch;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_store(input bit times3);
        for (int i = 0; i < 32; i++) begin
            base[i]    = times3 ? 32'(i * 3) : ($urandom | 32'h1);
            ref_mem[i] = base[i];
        end
        epoch++;
    endtask

    task automatic check_write_port_idle();
`ifdef LUTRAM_SCAN_CLEAR_EN
        check("wdata_zero", {32'd0, RAM_WDATA}, 64'd0);
`else
        check("write_port_tied", {26'd0, RAM_WE, RAM_WADDR, RAM_WDATA}, 64'd0);
`endif
    endtask

    // One scan from the negedge in IDLE; mode 0 ready=1, 1 random, 2 pattern 1,0,0,1.
    task automatic run_scan(input int s, input int e, input int mode, input int abort_after, input bit poke);
        int          n;
        int          exp_a[$];
        logic [31:0] exp_d[$];
        int          we_a[$];
        int          hs;
        int          cyc;
        bit          held_v;
        logic [4:0]  held_a;
        logic [4:0]  held_ra;
        logic [31:0] held_d;
        bit          rdy;
        n = ((e - s + 32) % 32) + 1;
        for (int i = 0; i < n; i++) begin
            exp_a.push_back((s + i) % 32);
            exp_d.push_back(ref_mem[(s + i) % 32]);
        end
        START = 1'b1; START_ADDR = 5'(s); END_ADDR = 5'(e); OUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0; START_ADDR = 5'($urandom); END_ADDR = 5'($urandom);
        check("busy_after_start", {63'd0, BUSY}, 64'd1);
        check("ram_addr_start", {59'd0, RAM_ADDR}, 64'(s));
        check("valid_low_first", {63'd0, OUT_VALID}, 64'd0);
        hs = 0; cyc = 0; held_v = 1'b0;
        while (hs < n && cyc < 400) begin
            if (abort_after >= 0 && hs == abort_after) break;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
            endcase
            OUT_READY = rdy;
            START = (poke && (cyc == 2 || cyc == 3));
            if (START) begin START_ADDR = 5'($urandom); END_ADDR = 5'($urandom); end
            if (held_v) begin
                check("stall_valid", {63'd0, OUT_VALID}, 64'd1);
                check("stall_addr", {59'd0, OUT_ADDR}, {59'd0, held_a});
                check("stall_data", {32'd0, OUT_DATA}, {32'd0, held_d});
                check("stall_ram_addr", {59'd0, RAM_ADDR}, {59'd0, held_ra});
            end
            check("busy_mid", {63'd0, BUSY}, 64'd1);
            check("no_done_mid", {63'd0, DONE}, 64'd0);
            check_write_port_idle();
            if (RAM_WE) we_a.push_back(int'(RAM_WADDR));
            held_v = 1'b0;
            if (OUT_VALID && rdy) begin
                check("entry_addr", {59'd0, OUT_ADDR}, 64'(exp_a[hs]));
                check("entry_data", {32'd0, OUT_DATA}, {32'd0, exp_d[hs]});
                hs++;
            end else if (OUT_VALID) begin
                held_v = 1'b1; held_a = OUT_ADDR; held_d = OUT_DATA; held_ra = RAM_ADDR;
            end
            @(negedge CLK);
            cyc++;
        end
        START = 1'b0;
        if (abort_after >= 0 && hs == abort_after) begin
            ABORT = 1'b1; OUT_READY = 1'b0;
            check("no_write_on_abort", {63'd0, RAM_WE}, 64'd0);
            @(negedge CLK);
            ABORT = 1'b0;
            check("abort_valid", {63'd0, OUT_VALID}, 64'd0);
            check("abort_busy", {63'd0, BUSY}, 64'd0);
            check("abort_done", {63'd0, DONE}, 64'd0);
            for (int k = 0; k < 3; k++) begin
                @(negedge CLK);
                check("abort_no_done_later", {62'd0, DONE, BUSY}, 64'd0);
            end
            epoch++;
            for (int i = 0; i < 32; i++) ref_mem[i] = base[i];
        end else begin
            check("scan_timeout", 64'(hs), 64'(n));
            if (mode == 0) check("throughput", 64'(cyc), 64'(n + 1));
            check("done_pulse", {62'd0, DONE, BUSY}, 64'd2);
            check("valid_after_done", {63'd0, OUT_VALID}, 64'd0);
            @(negedge CLK);
            check("done_one_cycle", {63'd0, DONE}, 64'd0);
`ifdef LUTRAM_SCAN_CLEAR_EN
            check("clear_write_count", 64'(we_a.size()), 64'(n));
            for (int i = 0; i < n && i < we_a.size(); i++)
                check("clear_write_addr", 64'(we_a[i]), 64'(exp_a[i]));
            for (int i = 0; i < n; i++) ref_mem[exp_a[i]] = 32'd0;
`else
            check("no_writes", 64'(we_a.size()), 64'd0);
`endif
        end
    endtask

    initial begin
        epoch = 1;
        RST_N = 1'b0; START = 1'b0; START_ADDR = '0; END_ADDR = '0;
        ABORT = 1'b0; OUT_READY = 1'b0;
        for (int i = 0; i < 32; i++) base[i] = '0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        #2;
        check("reset_ctl", {61'd0, BUSY, DONE, OUT_VALID}, 64'd0);
        check("reset_addr", {54'd0, RAM_ADDR, OUT_ADDR}, 64'd0);
        check("reset_data", {32'd0, OUT_DATA}, 64'd0);
        check("reset_wport", {26'd0, RAM_WE, RAM_WADDR, RAM_WDATA}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);

        load_store(1'b1);
        run_scan(2, 5, 0, -1, 1'b0);
        load_store(1'b0);
        run_scan(30, 1, 0, -1, 1'b0);
        load_store(1'b0);
        run_scan(0, 3, 2, -1, 1'b0);
        load_store(1'b0);
        run_scan(0, 9, 0, 2, 1'b0);
        load_store(1'b0);
        run_scan(0, 9, 1, -1, 1'b0);
        load_store(1'b0);
        run_scan(10, 14, 1, -1, 1'b1);
        load_store(1'b0);
        run_scan(17, 17, 0, -1, 1'b0);

        START = 1'b1; ABORT = 1'b1; START_ADDR = 5'd3; END_ADDR = 5'd6;
        @(negedge CLK);
        START = 1'b0; ABORT = 1'b0;
        check("start_abort_idle", {62'd0, BUSY, OUT_VALID}, 64'd0);
        @(negedge CLK);
        check("start_abort_idle2", {62'd0, BUSY, DONE}, 64'd0);

        for (int t = 0; t < 6; t++) begin
            load_store(1'b0);
            run_scan(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1, -1, 1'b0);
        end

        load_store(1'b0);
        START = 1'b1; START_ADDR = 5'd4; END_ADDR = 5'd20; OUT_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("midreset_ctl", {61'd0, BUSY, DONE, OUT_VALID}, 64'd0);
        check("midreset_addr", {54'd0, RAM_ADDR, OUT_ADDR}, 64'd0);
        check("midreset_data", {32'd0, OUT_DATA}, 64'd0);
        check("midreset_wport", {26'd0, RAM_WE, RAM_WADDR, RAM_WDATA}, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        check("after_reset_no_done", {62'd0, BUSY, DONE}, 64'd0);

        load_store(1'b0);
        run_scan(4, 7, 1, -1, 1'b0);
        run_scan(4, 7, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
